// File: rtl/bus_slave_mc_pkg.sv
// Shared types and helpers for the multi-channel bus slave.
// State encoding is fixed so that bus analysers can decode the FSM directly.
package bus_slave_mc_pkg;

  localparam int MAX_CH = 16;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WRITE_ACK   = 3'd1,
    ST_WRITE_BURST = 3'd2,
    ST_READ_ACK    = 3'd3,
    ST_READ_BURST  = 3'd4,
    ST_WAIT        = 3'd5
  } state_e;

  // Channel-count / select-width sanity; a bad build treats every channel as invalid.
  function automatic bit cfg_ok(input int sel_w, input int num_ch);
    return (num_ch >= 1) && (num_ch <= MAX_CH) && (sel_w >= 1) && (sel_w < 31) &&
           ((1 << sel_w) >= num_ch);
  endfunction

  function automatic logic [MAX_CH-1:0] onehot(input logic [31:0] ch, input int num_ch);
    onehot = '0;
    if (ch < 32'(num_ch)) onehot = MAX_CH'(1) << ch;
  endfunction

endpackage

// File: rtl/bus_slave_mc_req.sv
// Per-channel request flags: write space and read data available.
// Latency 1 cycle from FIFO flags; no backpressure, flags simply follow the FIFOs.
module bus_slave_mc_req
  import bus_slave_mc_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [NUM_CH-1:0] w_fifo_prog_full_i,
  input  logic [NUM_CH-1:0] r_fifo_empty_i,
  output logic [NUM_CH-1:0] req_w_o,
  output logic [NUM_CH-1:0] req_r_o
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        req_w_o[i] <= 1'b0;
        req_r_o[i] <= 1'b0;
      end else begin
        req_w_o[i] <= ~w_fifo_prog_full_i[i];
        req_r_o[i] <= ~r_fifo_empty_i[i];
      end
    end
  end

endmodule

// File: rtl/bus_slave_mc.sv
// Bridges the local master bus to NUM_CH read/write FIFO pairs; channel picked in the address phase.
// Write data and read-valid lag the strobe by 1 cycle; full/empty or burst limit parks the FSM in WAIT.
module bus_slave_mc
  import bus_slave_mc_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_CH    = 4,
  parameter int CH_SEL_W  = 4,
  parameter int MAX_BURST = 256,
  parameter int CNT_W     = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     stb_i,
  input  logic                     we_i,
  input  logic                     m_rdy_i,
  input  logic [DATA_W-1:0]        dat_i,
  output logic                     ack_o,
  output logic                     abort_o,
  output logic                     s_rdy_o,
  output logic [DATA_W-1:0]        dat_o,
  output logic                     dat_o_enable_o,
  output logic [NUM_CH-1:0]        req_w_o,
  output logic [NUM_CH-1:0]        req_r_o,
  output logic [CNT_W-1:0]         xfer_cnt_o,
  output logic [NUM_CH-1:0]        r_fifo_rd_o,
  input  logic [NUM_CH*DATA_W-1:0] r_fifo_dat_i,
  input  logic [NUM_CH-1:0]        r_fifo_empty_i,
  output logic [DATA_W-1:0]        w_fifo_dat_o,
  output logic [NUM_CH-1:0]        w_fifo_dat_valid_o,
  input  logic [NUM_CH-1:0]        w_fifo_prog_full_i
);

  localparam bit          CFG_OK = cfg_ok(CH_SEL_W, NUM_CH);
  localparam logic [31:0] MAX_B  = 32'(MAX_BURST);

  state_e              state, state_nxt;
  logic [CH_SEL_W-1:0] ch_sel;
  logic [NUM_CH-1:0]   sel_oh;
  logic                ch_bad, ch_full, ch_empty, lim_at, lim_hit;
  logic                wr_stb, rd_stb;

  assign ch_bad   = !CFG_OK || (32'(ch_sel) >= 32'(NUM_CH));
  assign sel_oh   = ch_bad ? '0 : NUM_CH'(onehot(32'(ch_sel), NUM_CH));
  // An invalid channel selects nothing, so it reads as never-full / always-empty.
  assign ch_full  = |(w_fifo_prog_full_i & sel_oh);
  assign ch_empty = ~|(~r_fifo_empty_i & sel_oh);
  assign lim_at   = (MAX_B != 0) && (32'(xfer_cnt_o) >= MAX_B);
  assign lim_hit  = (MAX_B != 0) && (32'(xfer_cnt_o) + 32'd1 >= MAX_B);

  always_comb begin
    state_nxt = state;
    ack_o     = 1'b0;
    abort_o   = 1'b0;
    wr_stb    = 1'b0;
    rd_stb    = 1'b0;
    if (!reset_i) begin
      case (state)
        ST_IDLE: if (stb_i) state_nxt = we_i ? ST_WRITE_ACK : ST_READ_ACK;
        ST_WRITE_ACK: begin
          if (ch_bad || ch_full) begin
            abort_o   = 1'b1;
            state_nxt = ST_WAIT;
          end else begin
            ack_o     = 1'b1;
            wr_stb    = m_rdy_i && stb_i;
            state_nxt = (wr_stb && lim_hit) ? ST_WAIT : ST_WRITE_BURST;
          end
        end
        ST_WRITE_BURST: begin
          ack_o = 1'b1;
          if (!stb_i) state_nxt = ST_IDLE;
          else begin
            wr_stb = m_rdy_i && !lim_at;
            if (ch_full || lim_at || (m_rdy_i && lim_hit)) state_nxt = ST_WAIT;
          end
        end
        ST_READ_ACK: begin
          if (ch_bad || ch_empty) begin
            abort_o   = 1'b1;
            state_nxt = ST_WAIT;
          end else begin
            ack_o     = 1'b1;
            rd_stb    = 1'b1;
            state_nxt = lim_hit ? ST_WAIT : ST_READ_BURST;
          end
        end
        ST_READ_BURST: begin
          if (!stb_i) state_nxt = ST_IDLE;
          else if (ch_empty || lim_at) state_nxt = ST_WAIT;
          else begin
            ack_o  = 1'b1;
            rd_stb = 1'b1;
            if (lim_hit) state_nxt = ST_WAIT;
          end
        end
        ST_WAIT: if (!stb_i) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign r_fifo_rd_o    = sel_oh & {NUM_CH{rd_stb}};
  assign dat_o_enable_o = s_rdy_o;

  always_comb begin
    dat_o = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (sel_oh[i]) dat_o = dat_o | r_fifo_dat_i[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state              <= ST_IDLE;
      ch_sel             <= '0;
      xfer_cnt_o         <= '0;
      s_rdy_o            <= 1'b0;
      w_fifo_dat_o       <= '0;
      w_fifo_dat_valid_o <= '0;
    end else begin
      state              <= state_nxt;
      w_fifo_dat_o       <= dat_i;
      w_fifo_dat_valid_o <= sel_oh & {NUM_CH{wr_stb}};
      s_rdy_o            <= rd_stb;
      if (state == ST_IDLE && stb_i) begin
        ch_sel     <= dat_i[CH_SEL_W-1:0];
        xfer_cnt_o <= '0;
      end else if ((wr_stb || rd_stb) && !(&xfer_cnt_o)) begin
        xfer_cnt_o <= xfer_cnt_o + CNT_W'(1);
      end
    end
  end

  bus_slave_mc_req #(.NUM_CH(NUM_CH)) u_req (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .w_fifo_prog_full_i (w_fifo_prog_full_i),
    .r_fifo_empty_i     (r_fifo_empty_i),
    .req_w_o            (req_w_o),
    .req_r_o            (req_r_o)
  );

endmodule

// File: tb/tb_bus_slave_mc.sv
// Directed bench for bus_slave_mc: scoreboarded write/read data, aborts, burst limit, reset.
module tb_bus_slave_mc;
  import bus_slave_mc_pkg::*;

  localparam int DW = 32;
  localparam int NC = 4;
  localparam int CW = 16;

  typedef struct {
    logic [NC-1:0] oh;
    logic [DW-1:0] dat;
  } wexp_t;

  logic clk = 1'b0, reset = 1'b1, stb = 1'b0, we = 1'b0, m_rdy = 1'b0;
  logic [DW-1:0]    dat_in = '0;
  logic [NC-1:0]    prog_full = '0, r_ne_force = '0, r_empty;
  logic [NC*DW-1:0] r_dat;

  logic ack, abort, s_rdy, den;
  logic [DW-1:0] dat_out, w_dat;
  logic [NC-1:0] req_w, req_r, rd, w_vld;
  logic [CW-1:0] xfer;

  logic l_ack, l_abort, l_s_rdy, l_den;
  logic [DW-1:0] l_dat_out, l_w_dat;
  logic [NC-1:0] l_req_w, l_req_r, l_rd, l_w_vld;
  logic [CW-1:0] l_xfer;

  int checks = 0, failures = 0;
  int wr_cnt = 0, lim_cnt = 0, rd_pops = 0;
  bit mon_on = 1'b0, prev_rd = 1'b0, prev_rst = 1'b1;
  wexp_t wq[$];
  logic [DW-1:0] rq[$];
  wexp_t wx;

  always #5 clk = ~clk;

  bus_slave_mc dut (
    .clk_i(clk), .reset_i(reset), .stb_i(stb), .we_i(we), .m_rdy_i(m_rdy), .dat_i(dat_in),
    .ack_o(ack), .abort_o(abort), .s_rdy_o(s_rdy), .dat_o(dat_out), .dat_o_enable_o(den),
    .req_w_o(req_w), .req_r_o(req_r), .xfer_cnt_o(xfer), .r_fifo_rd_o(rd),
    .r_fifo_dat_i(r_dat), .r_fifo_empty_i(r_empty), .w_fifo_dat_o(w_dat),
    .w_fifo_dat_valid_o(w_vld), .w_fifo_prog_full_i(prog_full)
  );

  bus_slave_mc #(.MAX_BURST(4)) dut_lim (
    .clk_i(clk), .reset_i(reset), .stb_i(stb), .we_i(we), .m_rdy_i(m_rdy), .dat_i(dat_in),
    .ack_o(l_ack), .abort_o(l_abort), .s_rdy_o(l_s_rdy), .dat_o(l_dat_out), .dat_o_enable_o(l_den),
    .req_w_o(l_req_w), .req_r_o(l_req_r), .xfer_cnt_o(l_xfer), .r_fifo_rd_o(l_rd),
    .r_fifo_dat_i(r_dat), .r_fifo_empty_i(r_empty), .w_fifo_dat_o(l_w_dat),
    .w_fifo_dat_valid_o(l_w_vld), .w_fifo_prog_full_i(prog_full)
  );

  // Channel 1 read FIFO, non-fall-through: data appears the cycle after a pop.
  logic [DW-1:0] rmem [16];
  int            rptr = 0, rcnt = 0;
  logic [DW-1:0] rdat1 = '0;
  logic          ch1_empty;
  assign ch1_empty = (rptr >= rcnt);
  always @(posedge clk) begin
    if (rd[1] && !ch1_empty) begin
      rdat1 <= rmem[rptr[3:0]];
      rptr  <= rptr + 1;
    end
  end
  assign r_empty = {2'b11, ch1_empty, 1'b1} & ~r_ne_force;
  assign r_dat   = {{(2*DW){1'b0}}, rdat1, {DW{1'b0}}};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr_word(input int ch, input logic [DW-1:0] d);
    m_rdy  = 1'b1;
    dat_in = d;
    wq.push_back('{oh: NC'(1 << ch), dat: d});
  endtask

  task automatic load1(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      rmem[rcnt+i] = base + DW'(i);
      rq.push_back(base + DW'(i));
    end
    rcnt = rcnt + n;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (w_vld != '0) begin
        wr_cnt++;
        if (wq.size() == 0) chk("wr_unexpected", 64'(w_vld), 0);
        else begin
          wx = wq.pop_front();
          chk("wr_vld", 64'(w_vld), 64'(wx.oh));
          chk("wr_dat", 64'(w_dat), 64'(wx.dat));
        end
      end
      if (l_w_vld != '0) lim_cnt++;
      if (rd != '0) begin
        rd_pops++;
        chk("rd_pop_onehot_nonempty", {($countones(rd) == 1), |(rd & r_empty)}, 2'b10);
      end
      chk("s_rdy_lag", {den, s_rdy}, {2{prev_rd & ~prev_rst}});
      if (s_rdy) begin
        if (rq.size() == 0) chk("rd_unexpected", 64'(s_rdy), 0);
        else chk("rd_dat", 64'(dat_out), 64'(rq.pop_front()));
      end
      prev_rd  = |rd;
      prev_rst = reset;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, p0;
    // Reset state
    step(); step();
    mon_on = 1'b1;
    chk("rst_state", dut.state, ST_IDLE);
    chk("rst_outs", {ack, abort, s_rdy, den, rd, w_vld}, 0);
    chk("rst_req", {req_w, req_r}, 0);
    chk("rst_wdat_cnt", {w_dat, xfer}, 0);
    reset = 1'b0;
    step();
    chk("req_after_rst", {req_w, req_r}, {4'b1111, ~r_empty});

    // Write 5 words to channel 2
    stb = 1'b1; we = 1'b1; dat_in = 2;
    step();
    chk("wr_ack_state", dut.state, ST_WRITE_ACK);
    chk("wr_ack", {ack, abort}, 2'b10);
    n0 = wr_cnt;
    for (int k = 0; k < 5; k++) begin
      wr_word(2, 32'hA0 + k);
      step();
      chk("wr_burst_ack", ack, 1);
    end
    m_rdy = 1'b0;
    step();
    chk("wr_strobes", wr_cnt - n0, 5);
    chk("wr_xfer", xfer, 5);
    stb = 1'b0;
    step();
    chk("wr_idle", dut.state, ST_IDLE);

    // Read 3 words from channel 1
    load1(32'hB0, 3);
    stb = 1'b1; we = 1'b0; dat_in = 1;
    step();
    chk("rd_ack", {ack, abort, rd}, {2'b10, 4'b0010});
    p0 = rd_pops;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("rd_no_abort", abort, 0);
      if (dut.state == ST_WAIT) break;
    end
    chk("rd_wait", dut.state, ST_WAIT);
    chk("rd_pops", rd_pops - p0, 3);
    chk("rd_xfer", xfer, 3);
    chk("rd_q_drained", rq.size(), 0);
    stb = 1'b0;
    step();
    chk("rd_idle", dut.state, ST_IDLE);

    // Invalid channel, read then write
    stb = 1'b1; we = 1'b0; dat_in = 6;
    step();
    chk("bad_rd_abort", {ack, abort, rd}, {2'b01, 4'b0000});
    step();
    chk("bad_rd_wait", {dut.state, abort}, {ST_WAIT, 1'b0});
    stb = 1'b0;
    step();
    n0 = wr_cnt;
    stb = 1'b1; we = 1'b1; dat_in = 6;
    step();
    chk("bad_wr_abort", {ack, abort}, 2'b01);
    m_rdy = 1'b1; dat_in = 32'hDEAD;
    step();
    chk("bad_wr_wait", dut.state, ST_WAIT);
    chk("bad_dat_o", dat_out, 0);
    m_rdy = 1'b0; stb = 1'b0;
    step(); step();
    chk("bad_no_strobe", wr_cnt - n0, 0);
    chk("bad_idle_xfer", {dut.state, xfer}, {ST_IDLE, 16'd0});

    // Channel 3 full at address phase
    prog_full = 4'b1000;
    n0 = wr_cnt;
    stb = 1'b1; we = 1'b1; dat_in = 3;
    step();
    chk("full_abort", {ack, abort}, 2'b01);
    step();
    chk("full_wait", dut.state, ST_WAIT);
    stb = 1'b0; prog_full = '0;
    step(); step();
    chk("full_no_strobe", wr_cnt - n0, 0);

    // Channel 3 goes full mid-burst
    stb = 1'b1; we = 1'b1; dat_in = 3;
    step();
    chk("mid_ack", ack, 1);
    wr_word(3, 32'hD0); step();
    wr_word(3, 32'hD1); step();
    wr_word(3, 32'hD2); prog_full = 4'b1000;
    step();
    chk("mid_wait", {dut.state, ack}, {ST_WAIT, 1'b0});
    chk("req_w_lat", req_w, 4'b0111);
    m_rdy = 1'b0; stb = 1'b0; prog_full = '0;
    step();
    chk("mid_idle_xfer", {dut.state, xfer}, {ST_IDLE, 16'd3});
    chk("req_w_back", req_w, 4'b1111);

    // Burst limit of 4 on the limited instance, 10 words offered to ch0
    stb = 1'b1; we = 1'b1; dat_in = 0;
    step();
    chk("lim_ack", l_ack, 1);
    n0 = lim_cnt;
    for (int k = 0; k < 10; k++) begin
      wr_word(0, 32'hC0 + k);
      step();
      if (k == 3) begin
        chk("lim_wait", dut_lim.state, ST_WAIT);
        chk("lim_ack_drop", l_ack, 0);
      end
    end
    m_rdy = 1'b0;
    step();
    chk("lim_strobes", lim_cnt - n0, 4);
    chk("lim_xfer", l_xfer, 4);
    chk("unlim_xfer", xfer, 10);
    stb = 1'b0;
    step();

    // Reset in the middle of a read burst
    load1(32'hE0, 3);
    p0 = rptr;
    stb = 1'b1; we = 1'b0; dat_in = 1;
    step(); step();
    chk("rst_rb_state", dut.state, ST_READ_BURST);
    reset = 1'b1; prog_full = 4'b0101; r_ne_force = 4'b1000;
    step();
    chk("rst_mid_state", dut.state, ST_IDLE);
    chk("rst_mid_outs", {ack, abort, s_rdy, den, rd, w_vld, req_w, req_r}, 0);
    chk("rst_mid_cnt_wdat", {xfer, w_dat}, 0);
    chk("rst_mid_no_pop", rptr, p0 + 1);
    rq.delete();
    rcnt = rptr;
    reset = 1'b0; stb = 1'b0;
    step();
    chk("req_post_rst", {req_w, req_r}, {4'b1010, 4'b1000});
    prog_full = '0; r_ne_force = '0;
    step();
    chk("end_wq_empty", wq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_slave_mc.md
Name: bus_slave_mc

Overview:
- Parametrised multi-channel successor to the two-channel cPCI-side bus slave.
- Bridges the local master bus to NUM_CH independent read-FIFO/write-FIFO pairs.
- Channel is selected by the address-phase data word.
- Adds burst-length limiting, invalid-channel abort and a per-transfer word count.

Parameters:
- DATA_W, 32, bus and FIFO data width.
- NUM_CH, 4, number of FIFO channel pairs (1..16).
- CH_SEL_W, 4, address-phase bits used for channel select; must satisfy 2**CH_SEL_W >= NUM_CH.
- MAX_BURST, 256, maximum data words per transfer before forced WAIT; 0 = unlimited.
- CNT_W, 16, width of the transfer word counter.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  synchronous active-high reset
- stb_i  in  1  transfer strobe from master
- we_i  in  1  1 = write (master to FIFO), 0 = read
- m_rdy_i  in  1  master data valid (write data phase)
- dat_i  in  DATA_W  address-phase word / write data
- ack_o  out  1  slave accepts transfer
- abort_o  out  1  slave refuses transfer
- s_rdy_o  out  1  read data valid on dat_o
- dat_o  out  DATA_W  read data, muxed from selected channel
- dat_o_enable_o  out  1  bus driver enable, equals s_rdy_o
- req_w_o  out  NUM_CH  per channel: write space available
- req_r_o  out  NUM_CH  per channel: read data available
- xfer_cnt_o  out  CNT_W  words moved in current/last transfer
- r_fifo_rd_o  out  NUM_CH  read-FIFO pop strobes
- r_fifo_dat_i  in  NUM_CH*DATA_W  read-FIFO data, channel i at [i*DATA_W +: DATA_W]
- r_fifo_empty_i  in  NUM_CH  read-FIFO empty flags
- w_fifo_dat_o  out  DATA_W  write data, shared by all channels
- w_fifo_dat_valid_o  out  NUM_CH  per-channel write strobe
- w_fifo_prog_full_i  in  NUM_CH  write-FIFO programmable-full flags

Behaviour:
- Reset: state IDLE, ch_sel=0, xfer_cnt_o=0. All of the following are 0: req_w_o, req_r_o, s_rdy_o, dat_o_enable_o, w_fifo_dat_o, w_fifo_dat_valid_o, ack_o, abort_o, r_fifo_rd_o. Reset mid-transfer returns to IDLE next edge with no further FIFO strobes.
- req_w_o[i] <= ~w_fifo_prog_full_i[i]; req_r_o[i] <= ~r_fifo_empty_i[i]. Both registered, 1-cycle latency.
- Channel latch: in IDLE with stb_i=1, ch_sel <= dat_i[CH_SEL_W-1:0] and xfer_cnt_o <= 0. ch_bad = (ch_sel >= NUM_CH).
- States: IDLE, WRITE_ACK, WRITE_BURST, READ_ACK, READ_BURST, WAIT.
- IDLE: stb&we -> WRITE_ACK; stb&~we -> READ_ACK; else stay. Outputs ack=abort=rd=0.
- WRITE_ACK (comb):
  - ch_bad: abort=1, ack=0, -> WAIT.
  - Else ack=~prog_full[ch], abort=prog_full[ch]; -> WRITE_BURST if not full, else WAIT.
- WRITE_BURST: ack=1. Priority: ~stb -> IDLE; prog_full[ch] -> WAIT; limit reached -> WAIT.
- Write data path (all states, registered):
  - w_fifo_dat_o <= dat_i.
  - w_fifo_dat_valid_o <= onehot(ch_sel) & {NUM_CH{m_rdy_i & ~ch_bad}}.
  - Latency 1 cycle.
- READ_ACK (comb):
  - ch_bad or empty[ch]: abort=1, ack=0, rd=0, -> WAIT.
  - Else ack=1, r_fifo_rd_o[ch]=1, -> READ_BURST.
- READ_BURST:
  - ~stb: ack=rd=0, -> IDLE.
  - empty[ch] or limit reached: ack=rd=0, abort=0, -> WAIT.
  - Else ack=1, r_fifo_rd_o[ch]=1.
- Read data: s_rdy_o <= |r_fifo_rd_o, i.e. 1 cycle after pop (FIFO first-word-fall-through not assumed). dat_o = r_fifo_dat_i slice selected by ch_sel, combinational. For ch_bad, dat_o = 0.
- xfer_cnt_o increments on each w_fifo_dat_valid_o or r_fifo_rd_o strobe. Saturates at all-ones. Holds after transfer until next address phase.
- Limit reached = MAX_BURST != 0 and (xfer_cnt_o + current strobe) == MAX_BURST. The strobe that reaches the limit is still issued; none after.
- WAIT: all comb outputs 0. ~stb -> IDLE.
- Simultaneous ~stb and full/empty: IDLE wins.
- Exactly one r_fifo_rd_o bit is ever high. Never pop an empty FIFO.

Decomposition:
- Package bus_slave_mc_pkg:
  - state enum (3-bit, encodings 0..5 as listed).
  - function onehot(ch_sel, NUM_CH).
  - localparam check CH_SEL_W vs NUM_CH.
- Sub-module bus_slave_mc_req: per-channel registered req_w/req_r flags, generate-loop over NUM_CH.

Test Plan:
- Reset, then NUM_CH=4 with ch2 write FIFO not full; stb, we, dat_i=2, then 5 m_rdy words 0xA0..A4 -> ack high from WRITE_ACK; w_fifo_dat_valid_o=4'b0100 for 5 cycles, each 1 cycle after m_rdy; xfer_cnt_o=5; ~stb -> IDLE.
- Read ch1 holding 3 words, empty rises after third pop -> r_fifo_rd_o=4'b0010 for 3 cycles; s_rdy_o for 3 cycles lagging by 1; dat_o from ch1 slice; -> WAIT, abort stays 0.
- Address phase dat_i=6 with NUM_CH=4 (read and write) -> abort_o=1 in ACK state; no FIFO strobes; WAIT until ~stb.
- MAX_BURST=4, write 10 words to ch0 -> exactly 4 valid strobes; state WAIT after 4th; ack drops; xfer_cnt_o=4.
- Write to ch3 with prog_full[3]=1 at WRITE_ACK -> abort_o=1, ack_o=0, no strobes; separately prog_full rising mid-burst -> WAIT next edge.
- Assert reset_i mid READ_BURST -> next edge all outputs 0, state IDLE, req_* 0, then req_* reflect flags 1 cycle after reset deasserts.
